// File: rtl/exp_sum_accumulator.sv
// Sequential pseudo-softmax stage: sums 2^x over a logit vector and
// produces a fixed-point log2 of the sum for the subtractor array.
module exp_sum_accumulator #(
   parameter int NUM_INPUTS = 10,
   parameter int MANT_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int EXP_WIDTH  = 9,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus,
   output logic                             busy,
   output logic                             valid,
   output logic [EXP_WIDTH-1:0]             exp_sum
);

   localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int PW    = $clog2(ACC_WIDTH);
   localparam int INT_W = MANT_WIDTH - FRAC_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      NORM  = 2'd2
   } state_t;

   state_t                           r_state;
   state_t                           w_next;
   logic [NUM_INPUTS*MANT_WIDTH-1:0] r_bus;
   logic [ACC_WIDTH-1:0]             r_acc;
   logic [IDX_W-1:0]                 r_idx;
   logic                             r_valid;
   logic [EXP_WIDTH-1:0]             r_exp_sum;

   logic [MANT_WIDTH-1:0]            w_x;
   logic [FRAC_BITS:0]               w_mant;
   logic [INT_W-1:0]                 w_k;
   logic [ACC_WIDTH-1:0]             w_term;
   logic [PW-1:0]                    w_p;
   logic [PW-1:0]                    w_ipart;
   logic [FRAC_BITS-1:0]             w_frac;
   logic                             w_last;

   // Linear-mantissa 2^x: (1.f) shifted by the integer part
   always_comb begin
      w_x    = MANT_WIDTH'(r_bus >> (r_idx * MANT_WIDTH));
      w_mant = {1'b1, w_x[FRAC_BITS-1:0]};
      w_k    = w_x[MANT_WIDTH-1:FRAC_BITS];
      w_term = ACC_WIDTH'(w_mant) << w_k;
      w_last = (r_idx == IDX_W'(NUM_INPUTS - 1));
   end

   // Leading-one position, then the FRAC_BITS just below it
   always_comb begin
      w_p = '0;
      for (int i = 0; i < ACC_WIDTH; i++) begin
         if (r_acc[i]) w_p = PW'(i);
      end
      w_ipart = w_p - PW'(FRAC_BITS);
      w_frac  = FRAC_BITS'(r_acc >> w_ipart);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = ACCUM;
         ACCUM:   if (w_last) w_next = NORM;
         NORM:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus     <= '0;
         r_acc     <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_exp_sum <= '0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_bus <= input_bus;
                  r_acc <= '0;
                  r_idx <= '0;
               end
            end
            ACCUM: begin
               r_acc <= r_acc + w_term;
               r_idx <= r_idx + IDX_W'(1);
            end
            NORM: begin
               r_exp_sum <= EXP_WIDTH'({w_ipart, w_frac});
               r_valid   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign valid   = r_valid;
   assign exp_sum = r_exp_sum;

endmodule

// File: tb/tb_exp_sum_accumulator.sv
// Self-checking bench for exp_sum_accumulator: fixed vectors, control
// corners and random vectors against an arithmetic reference model.
module tb_exp_sum_accumulator;

   localparam int N  = 10;
   localparam int MW = 8;
   localparam int BW = N * MW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [BW-1:0] input_bus;
   logic          busy;
   logic          valid;
   logic [8:0]    exp_sum;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_sum_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .input_bus (input_bus),
      .busy      (busy),
      .valid     (valid),
      .exp_sum   (exp_sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string         name;
      logic [BW-1:0] bus;
      int            exp;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // log2 of sum(2^x) using the linear-mantissa rule, in plain arithmetic
   function automatic int ref_exp(input logic [BW-1:0] bus);
      longint acc;
      longint t;
      int     p;
      int     k;
      int     f;
      logic [MW-1:0] x;
      acc = 0;
      for (int i = 0; i < N; i++) begin
         x   = bus[i*MW +: MW];
         k   = int'(x) / 16;
         f   = int'(x) % 16;
         acc = acc + longint'(16 + f) * (longint'(1) << k);
      end
      p = 0;
      t = acc;
      while (t > 1) begin
         t = t / 2;
         p++;
      end
      f = int'(((acc - (longint'(1) << p)) * 16) >> p);
      return (p - 4) * 16 + f;
   endfunction

   function automatic logic [BW-1:0] rand_bus();
      logic [BW-1:0] b;
      for (int i = 0; i < N; i++) b[i*MW +: MW] = MW'($urandom);
      return b;
   endfunction

   function automatic logic [BW-1:0] fill(input logic [MW-1:0] v);
      logic [BW-1:0] b;
      for (int i = 0; i < N; i++) b[i*MW +: MW] = v;
      return b;
   endfunction

   // One vector: latency, busy width, result, single-cycle valid
   task automatic run_vec(input string name, input logic [BW-1:0] bus,
                          input int exp, input bit noisy);
      int lat;
      int bcnt;
      @(negedge clk);
      start     = 1'b1;
      input_bus = bus;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = -1;
      bcnt  = busy ? 1 : 0;
      for (int n = 1; n <= 30; n++) begin
         if (noisy) begin
            input_bus = rand_bus();
            start     = 1'($urandom);
         end
         @(posedge clk);
         #1;
         if (valid) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
      end
      start = 1'b0;
      chk({name, " latency"}, lat, N + 1);
      chk({name, " busy_cycles"}, bcnt, N + 1);
      chk({name, " exp_sum"}, int'(exp_sum), exp);
      @(posedge clk);
      #1;
      chk({name, " valid_pulse"}, int'(valid), 0);
      chk({name, " held"}, int'(exp_sum), exp);
   endtask

   vec_t tbl[4];

   initial begin
      logic [BW-1:0] b;
      int            vt[$];
      int            exp;
      int            seen;

      tbl[0] = '{"zeros", fill(8'h00), 52};
      tbl[1] = '{"x0_40", {fill(8'h00) | BW'(8'h40)}, 73};
      tbl[2] = '{"all80", fill(8'h80), 180};
      tbl[3] = '{"allFF", fill(8'hFF), 307};

      rst_n     = 1'b0;
      start     = 1'b1;
      input_bus = rand_bus();
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst valid", int'(valid), 0);
      chk("rst exp_sum", int'(exp_sum), 0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle busy", int'(busy), 0);
      chk("idle valid", int'(valid), 0);
      chk("idle exp_sum", int'(exp_sum), 0);

      foreach (tbl[i]) run_vec(tbl[i].name, tbl[i].bus, tbl[i].exp, 1'b0);

      run_vec("noisy_allFF", fill(8'hFF), 307, 1'b1);

      // start held high: one result every N+2 cycles
      b = fill(8'h80);
      @(negedge clk);
      start     = 1'b1;
      input_bus = b;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            vt.push_back(cyc);
            chk("b2b exp_sum", int'(exp_sum), 180);
         end
      end
      start = 1'b0;
      chk("b2b count", vt.size(), 3);
      for (int i = 1; i < vt.size(); i++)
         chk("b2b spacing", vt[i] - vt[i-1], N + 2);
      repeat (N + 3) @(posedge clk);

      // reset mid-ACCUM aborts without a result
      @(negedge clk);
      start     = 1'b1;
      input_bus = fill(8'h33);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort busy", int'(busy), 0);
      chk("abort valid", int'(valid), 0);
      chk("abort exp_sum", int'(exp_sum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk);
         #1;
         if (valid) seen++;
      end
      chk("abort no_valid", seen, 0);
      run_vec("after_abort", fill(8'h33), ref_exp(fill(8'h33)), 1'b0);

      for (int r = 0; r < 20; r++) begin
         b   = rand_bus();
         exp = ref_exp(b);
         run_vec($sformatf("rand%0d", r), b, exp, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
